// File: rtl/qspi_lat_pkg.sv
// Shared types and defaults for the QSPI read-latency emulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package qspi_lat_pkg;

    localparam int DEF_DATA_W  = 4;
    localparam int DEF_NUM_SEL = 3;
    localparam int DEF_MAX_LAT = 5;

    localparam int SEL_FLASH = 0;
    localparam int SEL_RAM_A = 1;
    localparam int SEL_RAM_B = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

endpackage

// File: rtl/qspi_delay_line.sv
// Tagged shift register with a variable read tap and a synchronous valid-clear.
// Latency: tap clocks (tap 1..DEPTH); tap 0 reads as zero.
// Backpressure: none, shifts every cycle.
module qspi_delay_line
    import qspi_lat_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_MAX_LAT,
    parameter int LAT_W  = $clog2(DEF_MAX_LAT + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_dat,
    input  logic              in_vld,
    input  logic              clr_vld,
    input  logic [LAT_W-1:0]  tap,
    output logic [DATA_W-1:0] out_dat
);

    logic [DATA_W-1:0] stg_dat [DEPTH];
    logic [DEPTH-1:0]  stg_vld;

    // Shift every cycle; clr_vld invalidates older stages but keeps the new sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) stg_dat[k] <= '0;
            stg_vld <= '0;
        end else begin
            stg_dat[0] <= in_dat;
            stg_vld[0] <= in_vld;
            for (int k = 1; k < DEPTH; k++) begin
                stg_dat[k] <= stg_dat[k-1];
                stg_vld[k] <= stg_vld[k-1] & ~clr_vld;
            end
        end
    end

    // Tap mux: stage tap-1, masked to zero when that stage holds no valid nibble.
    always_comb begin
        out_dat = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (int'(tap) == k + 1 && stg_vld[k]) out_dat = stg_dat[k];
        end
    end

endmodule

// File: rtl/qspi_latency_emulator.sv
// Per-chip-select QSPI read-latency emulator between PMOD data and the core.
// Latency: active_lat clocks (0 = combinational pass-through).
// Backpressure: none; latency switches only at transaction boundaries.
module qspi_latency_emulator
    import qspi_lat_pkg::*;
#(
    parameter  int DATA_W  = DEF_DATA_W,
    parameter  int NUM_SEL = DEF_NUM_SEL,
    parameter  int MAX_LAT = DEF_MAX_LAT,
    localparam int LAT_W   = $clog2(MAX_LAT + 1),
    localparam int IDX_W   = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SEL-1:0] sel_n,
    input  logic [DATA_W-1:0]  data_in,
    output logic [DATA_W-1:0]  data_out,
    input  logic [LAT_W-1:0]   cfg_rst_lat,
    input  logic               cfg_wr,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [LAT_W-1:0]   cfg_lat,
    output logic [LAT_W-1:0]   active_lat,
    output logic               drop,
    output logic               sel_conflict
);

    function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] v);
        if (int'(v) > MAX_LAT) return LAT_W'(MAX_LAT);
        return v;
    endfunction

    logic [LAT_W-1:0]  lat_tbl [NUM_SEL];
    logic [LAT_W-1:0]  sel_lat;
    logic [LAT_W-1:0]  drain_cnt;
    logic [DATA_W-1:0] line_dat;
    logic              any_sel;
    logic              multi_sel;
    logic              load_lat;
    logic              lat_chg;
    state_t            state, nxt_state;

    assign any_sel   = ~&sel_n;
    assign multi_sel = $countones(~sel_n) > 1;

    // Latency of the lowest-index asserted select wins, even under conflict.
    always_comb begin
        sel_lat = '0;
        for (int i = NUM_SEL - 1; i >= 0; i--) begin
            if (!sel_n[i]) sel_lat = lat_tbl[i];
        end
    end

    // Latency table: reset preload and runtime writes, out-of-range index ignored.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SEL; i++) begin
            if (!rst_n)
                lat_tbl[i] <= clamp_lat(cfg_rst_lat);
            else if (cfg_wr && int'(cfg_idx) == i)
                lat_tbl[i] <= clamp_lat(cfg_lat);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt_state;
    end

    // FSM next-state: drain for active_lat cycles so the last nibble gets out.
    always_comb begin
        nxt_state = state;
        case (state)
            IDLE:    if (any_sel) nxt_state = ACTIVE;
            ACTIVE:  if (!any_sel) nxt_state = (active_lat == '0) ? IDLE : DRAIN;
            DRAIN: begin
                if (any_sel)                      nxt_state = ACTIVE;
                else if (drain_cnt <= LAT_W'(1))  nxt_state = IDLE;
            end
            default: nxt_state = IDLE;
        endcase
    end

    // FSM outputs: latch a new latency on transaction start or on a mid-drain switch.
    always_comb begin
        lat_chg  = (state == DRAIN) && any_sel && (sel_lat != active_lat);
        load_lat = ((state == IDLE) && any_sel) || lat_chg;
        drop     = rst_n && lat_chg;
    end

    // Drain counter loads on leaving ACTIVE and counts down while draining.
    always_ff @(posedge clk) begin
        if (!rst_n)
            drain_cnt <= '0;
        else if (state == ACTIVE && !any_sel)
            drain_cnt <= active_lat;
        else if (state == DRAIN)
            drain_cnt <= drain_cnt - LAT_W'(1);
    end

    // Applied latency register.
    always_ff @(posedge clk) begin
        if (!rst_n)        active_lat <= clamp_lat(cfg_rst_lat);
        else if (load_lat) active_lat <= sel_lat;
    end

    // Sticky flag for more than one select low; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n)         sel_conflict <= 1'b0;
        else if (multi_sel) sel_conflict <= 1'b1;
    end

    qspi_delay_line #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_LAT),
        .LAT_W  (LAT_W)
    ) u_line (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_dat  (data_in),
        .in_vld  (any_sel),
        .clr_vld (lat_chg),
        .tap     (active_lat),
        .out_dat (line_dat)
    );

    // Output mux: zero-latency bypass or delay-line tap; forced low during reset.
    always_comb begin
        data_out = '0;
        if (rst_n) begin
            if (active_lat == '0) data_out = any_sel ? data_in : '0;
            else                  data_out = line_dat;
        end
    end

endmodule
